// File: rtl/dither_matrix_ctrl_pkg.sv
// Shared pixel-pipeline definitions for the ordered-dither threshold matrix:
// controller states, memory geometry and the power-up Bayer pattern.
package dither_matrix_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        LOAD
    } dither_ctrl_state_e;

    localparam int DITHER_WORDS   = 64;
    localparam int DITHER_ENTRY_W = 8;
    localparam int DITHER_WORD_W  = 4 * DITHER_ENTRY_W;
    localparam int DITHER_ADDR_W  = $clog2(DITHER_WORDS);

    // One 4x4 Bayer row per word; byte b holds column b.
    localparam logic [31:0] BAYER_ROWS [4] = '{
        32'hA020_8000,
        32'h60E0_40C0,
        32'h9010_B030,
        32'h50D0_70F0
    };

    typedef logic [DITHER_WORD_W-1:0] dither_mem_t [DITHER_WORDS];

    // Word w covers row y = w/4; the 4x4 tile repeats every 4 rows.
    function automatic dither_mem_t bayer_init();
        dither_mem_t m;
        for (int w = 0; w < DITHER_WORDS; w++) begin
            m[w] = BAYER_ROWS[(w / 4) % 4];
        end
        return m;
    endfunction

endpackage

// File: rtl/dither_matrix_ctrl_ram.sv
// 64x32 simple dual-port EBR holding the dither thresholds.
// Synchronous read; contents start as the tiled Bayer pattern.
module dither_matrix_ram
    import dither_matrix_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [DITHER_ADDR_W-1:0] waddr,
    input  logic [DITHER_WORD_W-1:0] wdata,
    input  logic                     re,
    input  logic [DITHER_ADDR_W-1:0] raddr,
    output logic [DITHER_WORD_W-1:0] rdata
);

    dither_mem_t mem = bayer_init();

    // Write port plus registered read; rdata holds while re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dither_matrix_ctrl.sv
// Dither matrix controller: lookup handshake, upload sequencing, drain/load FSM.
// Optional upload idle timeout enabled by defining DITHER_CTRL_TIMEOUT_EN.
module dither_matrix_ctrl
    import dither_matrix_ctrl_pkg::*;
#(
    parameter int TAG_W       = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frag_valid,
    output logic             frag_ready,
    input  logic [3:0]       frag_x,
    input  logic [3:0]       frag_y,
    input  logic [TAG_W-1:0] frag_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_dither,
    output logic [TAG_W-1:0] out_tag,
    input  logic             upl_start,
    input  logic             upl_wr,
    input  logic [31:0]      upl_data,
    output logic             upl_busy,
    output logic             upl_done,
    output logic             upl_err
);

    dither_ctrl_state_e state, state_nxt;

    logic [DITHER_ADDR_W-1:0] word_ptr, word_ptr_nxt;
    logic [1:0]               byte_sel;
    logic [DITHER_WORD_W-1:0] rd_word;
    logic                     fire;
    logic                     wr_en;
    logic                     last_wr;
    logic                     timeout;

    assign frag_ready = !rst && (state == RUN) && (!out_valid || out_ready);
    assign fire       = frag_valid && frag_ready;
    assign upl_busy   = !rst && (state != RUN);

    // A start in the same cycle as a word wins; the word is dropped.
    assign wr_en   = (state == LOAD) && upl_wr && !upl_start;
    assign last_wr = wr_en && (word_ptr == DITHER_ADDR_W'(DITHER_WORDS - 1));

`ifdef DITHER_CTRL_TIMEOUT_EN
    logic [12:0] idle_cnt;

    assign timeout = (state == LOAD) && !upl_wr && !upl_start
                   && (idle_cnt == 13'(TIMEOUT_CYC - 1));

    // Count idle LOAD cycles; any upload activity restarts the count.
    always_ff @(posedge clk) begin
        if (rst || state != LOAD || upl_wr || upl_start) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 13'd1;
        end
    end

    // Sticky abort flag, cleared by the next upload attempt.
    always_ff @(posedge clk) begin
        if (rst || upl_start) begin
            upl_err <= 1'b0;
        end else if (timeout) begin
            upl_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign upl_err = 1'b0;
`endif

    // Next state and word pointer; a restart rewinds the pointer in any state.
    always_comb begin
        state_nxt    = state;
        word_ptr_nxt = word_ptr;
        unique case (state)
            RUN: begin
                if (upl_start) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (timeout || last_wr) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (upl_start || timeout) begin
            word_ptr_nxt = '0;
        end else if (wr_en) begin
            word_ptr_nxt = word_ptr + DITHER_ADDR_W'(1);
        end
    end

    // Controller state, pointer and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            word_ptr <= '0;
            upl_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_ptr <= word_ptr_nxt;
            upl_done <= last_wr;
        end
    end

    // Output stage: capture tag and byte lane on accept, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            byte_sel  <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_tag   <= frag_tag;
            byte_sel  <= frag_x[1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_dither = out_valid
                      ? rd_word[{byte_sel, 3'b000} +: DITHER_ENTRY_W]
                      : '0;

    dither_matrix_ram u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (word_ptr),
        .wdata (upl_data),
        .re    (fire),
        .raddr ({frag_y, frag_x[3:2]}),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_dither_matrix_ctrl.sv
// Self-checking bench for dither_matrix_ctrl: entry-level matrix model,
// per-cycle output compare, directed and randomized traffic and uploads.
module tb_dither_matrix_ctrl;

    localparam int TAG_W = 64;
`ifdef DITHER_CTRL_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 4096;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             frag_valid;
    logic             frag_ready;
    logic [3:0]       frag_x;
    logic [3:0]       frag_y;
    logic [TAG_W-1:0] frag_tag;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_dither;
    logic [TAG_W-1:0] out_tag;
    logic             upl_start;
    logic             upl_wr;
    logic [31:0]      upl_data;
    logic             upl_busy;
    logic             upl_done;
    logic             upl_err;

    always #5 clk = ~clk;

    dither_matrix_ctrl #(
        .TAG_W       (TAG_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frag_valid (frag_valid),
        .frag_ready (frag_ready),
        .frag_x     (frag_x),
        .frag_y     (frag_y),
        .frag_tag   (frag_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dither (out_dither),
        .out_tag    (out_tag),
        .upl_start  (upl_start),
        .upl_wr     (upl_wr),
        .upl_data   (upl_data),
        .upl_busy   (upl_busy),
        .upl_done   (upl_done),
        .upl_err    (upl_err)
    );

    typedef struct {
        logic [7:0]       d;
        logic [TAG_W-1:0] tag;
    } exp_t;

    int bayer4 [4][4] = '{
        '{0, 128, 32, 160},
        '{192, 64, 224, 96},
        '{48, 176, 16, 144},
        '{240, 112, 208, 80}
    };
    logic [7:0] row1 [4] = '{8'd192, 8'd64, 8'd224, 8'd96};

    logic [7:0] model [256];
    exp_t       q [$];
    exp_t       e_new;
    bit         run_exp;
    bit         done_exp;
    bit         err_exp;
    int         n_chk;
    int         n_fail;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle compare against the entry model and expected-output queue.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("out_dither", 64'(out_dither), 64'(q[0].d));
                chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            end
            chk("frag_ready", 64'(frag_ready),
                64'(run_exp && (q.size() == 0 || out_ready)));
            chk("upl_busy", 64'(upl_busy), 64'(!run_exp));
            chk("upl_done", 64'(upl_done), 64'(done_exp));
            chk("upl_err", 64'(upl_err), 64'(err_exp));
            if (out_valid && out_ready && q.size() != 0) begin
                void'(q.pop_front());
            end
            if (frag_valid && frag_ready) begin
                e_new.d   = model[{frag_y, frag_x}];
                e_new.tag = frag_tag;
                q.push_back(e_new);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        done_exp = 1'b0;
    endtask

    task automatic drive(input int x, input int y, input logic [TAG_W-1:0] t);
        frag_valid = 1'b1;
        frag_x     = 4'(x);
        frag_y     = 4'(y);
        frag_tag   = t;
    endtask

    task automatic start_upload();
        upl_start = 1'b1;
        step();
        upl_start  = 1'b0;
        upl_wr     = 1'b0;
        frag_valid = 1'b0;
        run_exp    = 1'b0;
        err_exp    = 1'b0;
    endtask

    task automatic write_word(input int k, input logic [31:0] data);
        upl_wr     = 1'b1;
        upl_data   = data;
        frag_valid = ($urandom_range(0, 1) != 0);
        frag_x     = 4'($urandom_range(0, 15));
        frag_y     = 4'($urandom_range(0, 15));
        frag_tag   = {$urandom, $urandom};
        step();
        upl_wr     = 1'b0;
        frag_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            model[4 * k + b] = data[8 * b +: 8];
        end
        if (k == 63) begin
            run_exp  = 1'b1;
            done_exp = 1'b1;
        end
    endtask

    task automatic upload_random(input int n);
        for (int k = 0; k < n; k++) begin
            write_word(k, $urandom);
        end
    endtask

    task automatic scan_all();
        out_ready = 1'b1;
        for (int e = 0; e < 256; e++) begin
            drive(e % 16, e / 16, 64'(e) | 64'hC0DE_0000_0000_0000);
            step();
        end
        frag_valid = 1'b0;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        run_exp    = 1'b1;
        done_exp   = 1'b0;
        err_exp    = 1'b0;
        rst        = 1'b1;
        frag_valid = 1'b1;
        frag_x     = '0;
        frag_y     = '0;
        frag_tag   = '1;
        out_ready  = 1'b1;
        upl_start  = 1'b0;
        upl_wr     = 1'b0;
        upl_data   = '0;
        for (int e = 0; e < 256; e++) begin
            model[e] = 8'(bayer4[(e / 16) % 4][(e % 16) % 4]);
        end

        repeat (3) step();
        chk("rst_frag_ready", 64'(frag_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_dither", 64'(out_dither), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_upl_busy", 64'(upl_busy), 64'd0);
        chk("rst_upl_done", 64'(upl_done), 64'd0);
        chk("rst_upl_err", 64'(upl_err), 64'd0);
        rst        = 1'b0;
        frag_valid = 1'b0;
        step();

        drive(1, 0, 64'h1111_2222_3333_4444);
        step();
        frag_valid = 1'b0;
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_dither", 64'(out_dither), 64'd128);
        chk("first_tag", 64'(out_tag), 64'h1111_2222_3333_4444);
        step();

        for (int i = 0; i < 4; i++) begin
            drive(i, 1, 64'hA0 + 64'(i));
            step();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_dither", 64'(out_dither), 64'(row1[i]));
        end
        frag_valid = 1'b0;
        step();

        out_ready = 1'b0;
        drive(2, 3, 64'hFEED_0000_0000_0002);
        step();
        drive(7, 7, 64'hDEAD);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", 64'(frag_ready), 64'd0);
            chk("stall_dither", 64'(out_dither), 64'd208);
            chk("stall_tag", 64'(out_tag), 64'hFEED_0000_0000_0002);
            step();
        end
        frag_valid = 1'b0;
        out_ready  = 1'b1;
        step();
        chk("stall_consumed", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        drive(9, 4, 64'h0BAD_F00D);
        step();
        frag_valid = 1'b0;
        start_upload();
        repeat (3) step();
        chk("drain_hold", 64'(out_valid), 64'd1);
        upl_wr   = 1'b1;
        upl_data = 32'hFFFF_FFFF;
        step();
        upl_wr    = 1'b0;
        out_ready = 1'b1;
        step();
        for (int k = 0; k < 64; k++) begin
            write_word(k, 32'h0302_0100 + 32'(k) * 32'h0404_0404);
        end
        chk("done_pulse", 64'(upl_done), 64'd1);
        step();
        chk("done_single", 64'(upl_done), 64'd0);
        drive(5, 2, 64'h37);
        step();
        frag_valid = 1'b0;
        chk("ramp_lookup", 64'(out_dither), 64'd37);
        step();

        start_upload();
        repeat (2) step();
        upload_random(10);
        upl_wr   = 1'b1;
        upl_data = 32'hBAD0_BAD0;
        start_upload();
        upload_random(64);
        scan_all();

        start_upload();
        repeat (2) step();
        upload_random(5);
        rst = 1'b1;
        step();
        step();
        chk("midload_rst_busy", 64'(upl_busy), 64'd0);
        chk("midload_rst_ready", 64'(frag_ready), 64'd0);
        rst     = 1'b0;
        run_exp = 1'b1;
        step();
        scan_all();

        for (int c = 0; c < 500; c++) begin
            frag_valid = ($urandom_range(0, 3) != 0);
            frag_x     = 4'($urandom_range(0, 15));
            frag_y     = 4'($urandom_range(0, 15));
            frag_tag   = {$urandom, $urandom};
            out_ready  = ($urandom_range(0, 3) != 0);
            upl_wr     = ($urandom_range(0, 15) == 0);
            upl_data   = $urandom;
            if (c == 250) begin
                upl_wr    = 1'b0;
                out_ready = 1'b1;
                start_upload();
                repeat (2) step();
                upload_random(64);
            end else begin
                step();
            end
        end
        frag_valid = 1'b0;
        upl_wr     = 1'b0;
        out_ready  = 1'b1;
        step();
        step();

`ifdef DITHER_CTRL_TIMEOUT_EN
        start_upload();
        repeat (2) step();
        upload_random(3);
        repeat (15) step();
        chk("to_busy_before", 64'(upl_busy), 64'd1);
        step();
        run_exp = 1'b1;
        err_exp = 1'b1;
        chk("to_err", 64'(upl_err), 64'd1);
        chk("to_ready", 64'(frag_ready), 64'd1);
        drive(3, 3, 64'h77);
        step();
        frag_valid = 1'b0;
        step();
        start_upload();
        chk("to_err_clear", 64'(upl_err), 64'd0);
        repeat (2) step();
        upload_random(64);
        scan_all();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
